// File: rtl/uart_cmd_ctrl.sv
// Frames UART bytes as SYNC,OP,ARG[],CHK, checks XOR checksum and inter-byte timeout.
// cmd_valid_o rises the cycle after the CHK strobe; holds until cmd_ready_i, bytes arriving meanwhile are dropped (err_ovf_o).
module uart_cmd_ctrl #(
  parameter int          ARG_BYTES = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          TO_TICKS  = 640
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   s_tick_i,
  input  logic                   rx_done_tick_i,
  input  logic [7:0]             rx_data_i,
  output logic                   cmd_valid_o,
  input  logic                   cmd_ready_i,
  output logic [7:0]             cmd_op_o,
  output logic [8*ARG_BYTES-1:0] cmd_arg_o,
  output logic                   err_chk_o,
  output logic                   err_to_o,
  output logic                   err_ovf_o,
  output logic                   busy_o
);

  localparam int TW = $clog2(TO_TICKS + 1);
  localparam int IW = (ARG_BYTES > 1) ? $clog2(ARG_BYTES) : 1;

  localparam logic [TW-1:0] TO_LAST  = TW'(TO_TICKS - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TO_TICKS);
  localparam logic [IW-1:0] IDX_LAST = IW'(ARG_BYTES - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_OP   = 3'd1;
  localparam logic [2:0] S_ARG  = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [7:0]             op_q, op_d;
  logic [8*ARG_BYTES-1:0] arg_q, arg_d;
  logic [7:0]             chk_q, chk_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   err_chk_q, err_chk_d;
  logic                   err_to_q, err_to_d;
  logic                   err_ovf_q, err_ovf_d;
  logic                   in_frame;
  logic                   to_hit;

  assign in_frame = (state_q == S_OP) || (state_q == S_ARG) || (state_q == S_CHK);
  // The tick that completes the timeout aborts even if a byte lands in the same cycle.
  assign to_hit   = in_frame && s_tick_i && (timer_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    arg_d     = arg_q;
    chk_d     = chk_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    err_chk_d = 1'b0;
    err_to_d  = 1'b0;
    err_ovf_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (rx_done_tick_i && (rx_data_i == SYNC_BYTE)) begin
          state_d = S_OP;
        end
      end

      S_OP, S_ARG, S_CHK: begin
        if (to_hit) begin
          err_to_d = 1'b1;
          timer_d  = '0;
          state_d  = S_IDLE;
        end else if (rx_done_tick_i) begin
          timer_d = '0;
          case (state_q)
            S_OP: begin
              op_d    = rx_data_i;
              chk_d   = rx_data_i;
              idx_d   = '0;
              state_d = S_ARG;
            end
            S_ARG: begin
              arg_d[8*idx_q +: 8] = rx_data_i;
              chk_d               = chk_q ^ rx_data_i;
              if (idx_q == IDX_LAST) begin
                state_d = S_CHK;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
            default: begin
              if (rx_data_i == chk_q) begin
                state_d = S_HOLD;
              end else begin
                err_chk_d = 1'b1;
                state_d   = S_IDLE;
              end
            end
          endcase
        end else if (s_tick_i && (timer_q != TO_MAX)) begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_HOLD: begin
        if (rx_done_tick_i) begin
          err_ovf_d = 1'b1;
        end
        if (cmd_ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      arg_q     <= '0;
      chk_q     <= '0;
      timer_q   <= '0;
      idx_q     <= '0;
      err_chk_q <= 1'b0;
      err_to_q  <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      arg_q     <= arg_d;
      chk_q     <= chk_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      err_chk_q <= err_chk_d;
      err_to_q  <= err_to_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  assign cmd_valid_o = (state_q == S_HOLD);
  assign busy_o      = (state_q != S_IDLE);
  assign cmd_op_o    = op_q;
  assign cmd_arg_o   = arg_q;
  assign err_chk_o   = err_chk_q;
  assign err_to_o    = err_to_q;
  assign err_ovf_o   = err_ovf_q;

endmodule
